// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared types and sizing constants for the SNN classifier core and its
// front-end stages.
//   loader_state_t : state encoding of the image loader FSM
//   NUM_PIXELS     : pixels per input frame (28x28 binary image)
//   NUM_HIDDEN     : hidden-layer neuron count
//   NUM_OUTPUT     : output-layer neuron count (one per digit)
// ---------------------------------------------------------------------------
package snn_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int NUM_HIDDEN = 32;
    localparam int NUM_OUTPUT = 10;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        UNPACK    = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/ram_input_unit.sv
// ---------------------------------------------------------------------------
// ram_input_unit
// DEPTH x 1 single-port input-unit RAM holding one binary image frame.
// Read is synchronous (one-cycle latency, read-before-write), which maps
// onto a block RAM primitive.
//   clk  : system clock
//   addr : shared read/write address
//   data : write data (one pixel)
//   we   : write enable
//   q    : registered read data
// ---------------------------------------------------------------------------
module ram_input_unit #(
    parameter int DEPTH  = 784,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              data,
    input  logic              we,
    output logic              q
);

    logic mem [DEPTH];

    // Contents are deliberately never cleared; a new frame overwrites them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/snn_image_loader.sv
// ---------------------------------------------------------------------------
// snn_image_loader
// Front end of the SNN classifier. Receives a frame of NUM_PIXELS/8 bytes
// from the UART receiver, unpacks each byte LSB first into one-bit pixels
// stored in the input-unit RAM, starts the core once the frame is complete,
// serves the core's RAM reads, and latches the classified digit.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   rx_data    : received byte, valid with rx_rdy
//   rx_rdy     : one-cycle strobe for rx_data
//   frame_clr  : abort a partially loaded frame (ignored while busy)
//   core_addr  : core read address into the input-unit RAM
//   core_q     : RAM read data (one cycle after core_addr)
//   core_done  : core finished classification
//   core_digit : classification result, valid with core_done
//   start      : one-cycle pulse starting the core
//   busy       : core owns the frame (START / WAIT_DONE)
//   digit      : last classified digit, held
//   digit_vld  : one-cycle pulse when digit updates
//   ovr        : one-cycle pulse for every dropped byte
// ---------------------------------------------------------------------------
module snn_image_loader #(
    parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS,   // must be a multiple of 8
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic              frame_clr,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_q,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic              start,
    output logic              busy,
    output logic [3:0]        digit,
    output logic              digit_vld,
    output logic              ovr
);

    import snn_pkg::*;

    localparam int NUM_BYTES = NUM_PIXELS / 8;
    // First pixel address of the final byte of a frame.
    localparam int LAST_BYTE_BASE = (NUM_BYTES - 1) * 8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    loader_state_t     state_reg,     state_next;
    logic [ADDR_W-1:0] wr_addr_reg,   wr_addr_next;
    logic [2:0]        bit_cnt_reg,   bit_cnt_next;
    logic [7:0]        shift_reg,     shift_next;
    logic [7:0]        skid_data_reg, skid_data_next;
    logic              skid_vld_reg,  skid_vld_next;
    logic [3:0]        digit_reg,     digit_next;
    logic              digit_vld_reg, digit_vld_next;
    logic              ovr_reg,       ovr_next;

    // RAM-side signals
    logic              ram_we;
    logic              ram_data;
    logic [ADDR_W-1:0] ram_addr;

    // Decodes of the unpack position
    logic last_bit;     // 8th bit of the current byte is being written
    logic last_byte;    // the current byte is the final byte of the frame
    logic frame_done;   // the very last pixel of the frame is being written

    assign last_bit   = (bit_cnt_reg == 3'd7);
    assign last_byte  = (wr_addr_reg >= ADDR_W'(LAST_BYTE_BASE));
    assign frame_done = last_bit && (wr_addr_reg == ADDR_W'(NUM_PIXELS - 1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        wr_addr_next   = wr_addr_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        skid_data_next = skid_data_reg;
        skid_vld_next  = skid_vld_reg;
        digit_next     = digit_reg;
        digit_vld_next = 1'b0;
        ovr_next       = 1'b0;
        ram_we         = 1'b0;
        ram_data       = shift_reg[0];

        case (state_reg)
            LOAD: begin
                // frame_clr wins over a simultaneous byte, which is lost
                // silently (no ovr): the sender asked for the abort.
                if (frame_clr) begin
                    wr_addr_next  = '0;
                    skid_vld_next = 1'b0;
                end else if (rx_rdy) begin
                    shift_next   = rx_data;
                    bit_cnt_next = 3'd0;
                    state_next   = UNPACK;
                end
            end

            UNPACK: begin
                if (frame_clr) begin
                    wr_addr_next  = '0;
                    skid_vld_next = 1'b0;
                    state_next    = LOAD;
                end else begin
                    ram_we       = 1'b1;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    wr_addr_next = wr_addr_reg + ADDR_W'(1);
                    bit_cnt_next = bit_cnt_reg + 3'd1;   // wraps to 0 for the next byte

                    // Byte boundary: pick the next byte without a bubble
                    // from the skid buffer or straight from the receiver.
                    if (last_bit) begin
                        if (frame_done) begin
                            state_next = START;
                        end else if (skid_vld_reg) begin
                            shift_next    = skid_data_reg;
                            skid_vld_next = 1'b0;
                        end else if (rx_rdy) begin
                            shift_next = rx_data;
                        end else begin
                            state_next = LOAD;
                        end
                    end

                    // Incoming byte while unpacking. Anything beyond the
                    // frame's final byte, or arriving with the skid buffer
                    // occupied, is dropped.
                    if (rx_rdy) begin
                        if (last_byte || skid_vld_reg) begin
                            ovr_next = 1'b1;
                        end else if (!last_bit) begin
                            skid_data_next = rx_data;
                            skid_vld_next  = 1'b1;
                        end
                    end
                end
            end

            START: begin
                wr_addr_next = '0;
                state_next   = WAIT_DONE;
                ovr_next     = rx_rdy;
            end

            WAIT_DONE: begin
                ovr_next = rx_rdy;
                if (core_done) begin
                    digit_next     = core_digit;
                    digit_vld_next = 1'b1;
                    state_next     = LOAD;
                end
            end

            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= LOAD;
            wr_addr_reg   <= '0;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            skid_data_reg <= 8'd0;
            skid_vld_reg  <= 1'b0;
            digit_reg     <= 4'd0;
            digit_vld_reg <= 1'b0;
            ovr_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_addr_reg   <= wr_addr_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            skid_data_reg <= skid_data_next;
            skid_vld_reg  <= skid_vld_next;
            digit_reg     <= digit_next;
            digit_vld_reg <= digit_vld_next;
            ovr_reg       <= ovr_next;
        end
    end

    // ------------------------------------------------------------------
    // RAM: writes take the port while unpacking, otherwise the core reads.
    // ------------------------------------------------------------------
    assign ram_addr = ram_we ? wr_addr_reg : core_addr;

    ram_input_unit #(
        .DEPTH  (NUM_PIXELS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .data (ram_data),
        .we   (ram_we),
        .q    (core_q)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign start     = (state_reg == START);
    assign busy      = (state_reg == START) || (state_reg == WAIT_DONE);
    assign digit     = digit_reg;
    assign digit_vld = digit_vld_reg;
    assign ovr       = ovr_reg;

endmodule

// File: tb/tb_snn_image_loader.sv
module tb_snn_image_loader;

    localparam int NPIX   = 784;
    localparam int NBYTES = NPIX / 8;
    localparam int AW     = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_rdy = 1'b0;
    logic          frame_clr = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic          core_q;
    logic          core_done = 1'b0;
    logic [3:0]    core_digit = 4'd0;
    logic          start;
    logic          busy;
    logic [3:0]    digit;
    logic          digit_vld;
    logic          ovr;

    snn_image_loader #(.NUM_PIXELS(NPIX), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .frame_clr  (frame_clr),
        .core_addr  (core_addr),
        .core_q     (core_q),
        .core_done  (core_done),
        .core_digit (core_digit),
        .start      (start),
        .busy       (busy),
        .digit      (digit),
        .digit_vld  (digit_vld),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled on the falling edge, away from the active edge.
    int start_cnt = 0;
    int start_cyc = 0;
    int ovr_cnt   = 0;
    int dv_cnt    = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (start) begin
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
            end
            if (ovr)       ovr_cnt <= ovr_cnt + 1;
            if (digit_vld) dv_cnt  <= dv_cnt + 1;
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int last_rx_cyc = 0;

    // Reference model: bytes of the frame currently expected in the RAM.
    // Pixel p is bit (p mod 8) of byte (p div 8).
    logic [7:0] frame_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        rx_rdy      = 1'b1;
        last_rx_cyc = cyc;
        step();
        rx_rdy      = 1'b0;
    endtask

    // Send n frame bytes with a fixed spacing, recording them in the model.
    task automatic send_frame_bytes(input int n, input int gap, input bit alt);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            if (alt) b = (frame_q.size() % 2 == 0) ? 8'hA5 : 8'h3C;
            else     b = 8'($urandom);
            frame_q.push_back(b);
            send_byte(b);
            if (k != n - 1) repeat (gap - 1) step();
        end
    endtask

    task automatic wait_start(input int target);
        int n = 0;
        while (start_cnt < target && n < 40) begin
            step();
            n++;
        end
        chk("start_count", start_cnt, target);
    endtask

    task automatic read_pix(input int p, output logic v);
        core_addr = AW'(p);
        step();
        v = core_q;
    endtask

    task automatic check_frame();
        logic [7:0] b;
        logic       v;
        int         bad = 0;
        for (int p = 0; p < NPIX; p++) begin
            b = frame_q[p / 8];
            read_pix(p, v);
            if (v !== b[p % 8]) begin
                if (bad < 4) $display("pixel %0d observed=%0b model=%0b", p, v, b[p % 8]);
                bad++;
            end
        end
        chk("frame_pixels_wrong", bad, 0);
    endtask

    task automatic do_done(input logic [3:0] d);
        core_digit = d;
        core_done  = 1'b1;
        step();
        core_done  = 1'b0;
        chk("digit_vld_pulse", int'(digit_vld), 1);
        chk("digit_value", int'(digit), int'(d));
        step();
        chk("digit_vld_clear", int'(digit_vld), 0);
        chk("busy_after_done", int'(busy), 0);
    endtask

    initial begin : main
        logic [15:0] plan16;
        logic        v;
        int          ovr0;
        int          frame_last;

        // ---------------- Reset state ----------------
        repeat (3) step();
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_digit", int'(digit), 0);
        chk("rst_digit_vld", int'(digit_vld), 0);
        chk("rst_ovr", int'(ovr), 0);
        rst_n = 1'b1;
        step();

        // ---------------- Frame A: alternating A5/3C, 20-cycle spacing ----------------
        frame_q.delete();
        send_frame_bytes(NBYTES, 20, 1'b1);
        frame_last = last_rx_cyc;
        repeat (8) step();
        chk("busy_in_start", int'(busy), 1);
        send_byte(8'hFF);                    // lands in START: dropped
        repeat (3) step();
        send_byte(8'h00);                    // WAIT_DONE: dropped
        repeat (3) step();
        send_byte(8'hFF);                    // WAIT_DONE: dropped
        repeat (3) step();
        chk("start_count_A", start_cnt, 1);
        chk("start_latency_A", start_cyc - frame_last, 9);
        chk("ovr_busy_drops", ovr_cnt, 3);
        chk("busy_wait_done", int'(busy), 1);
        plan16 = 16'h3CA5;
        for (int p = 0; p < 16; p++) begin
            read_pix(p, v);
            chk($sformatf("plan_pix%0d", p), int'(v), int'(plan16[p]));
        end
        check_frame();
        chk("busy_after_reads", int'(busy), 1);
        chk("no_digit_vld_yet", dv_cnt, 0);

        // ---------------- Done path ----------------
        do_done(4'd7);
        core_digit = 4'd3;
        core_done  = 1'b1;                   // outside WAIT_DONE: ignored
        step();
        core_done  = 1'b0;
        step();
        chk("done_ignored_digit", int'(digit), 7);
        chk("done_ignored_vld", dv_cnt, 1);

        // ---------------- Back-to-back bytes ----------------
        frame_q.delete();
        ovr0 = ovr_cnt;
        rx_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rx_data = 8'($urandom);
            if (k < 2) frame_q.push_back(rx_data);
            step();
        end
        rx_rdy = 1'b0;
        repeat (20) step();
        chk("b2b_ovr", ovr_cnt - ovr0, 1);
        send_frame_bytes(NBYTES - 2, 10, 1'b0);
        frame_last = last_rx_cyc;
        wait_start(2);
        chk("start_latency_B", start_cyc - frame_last, 9);
        check_frame();
        do_done(4'($urandom_range(0, 15)));

        // ---------------- Abort with frame_clr ----------------
        frame_q.delete();
        send_frame_bytes(50, 10, 1'b0);
        repeat (10) step();
        ovr0 = ovr_cnt;
        frame_clr = 1'b1;
        rx_data   = 8'($urandom);
        rx_rdy    = 1'b1;                    // collides with the abort
        step();
        frame_clr = 1'b0;
        rx_rdy    = 1'b0;
        repeat (3) step();
        chk("clr_no_ovr", ovr_cnt - ovr0, 0);
        frame_q.delete();
        send_frame_bytes(NBYTES - 1, 10, 1'b0);
        repeat (20) step();
        chk("clr_no_early_start", start_cnt, 2);
        chk("clr_not_busy", int'(busy), 0);
        repeat (1) step();
        begin
            logic [7:0] b;
            b = 8'($urandom);
            frame_q.push_back(b);
            send_byte(b);
        end
        frame_last = last_rx_cyc;
        wait_start(3);
        chk("start_latency_clr", start_cyc - frame_last, 9);
        check_frame();
        do_done(4'($urandom_range(1, 15)));

        // ---------------- Reset in the middle of unpacking ----------------
        frame_q.delete();
        send_frame_bytes(10, 10, 1'b0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", int'(start), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_digit", int'(digit), 0);
        chk("mid_rst_digit_vld", int'(digit_vld), 0);
        chk("mid_rst_ovr", int'(ovr), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        frame_q.delete();
        ovr0 = ovr_cnt;
        send_frame_bytes(NBYTES, 10, 1'b0);
        frame_last = last_rx_cyc;
        repeat (2) step();
        send_byte(8'($urandom));             // past the final byte: dropped
        wait_start(4);
        chk("start_latency_rst", start_cyc - frame_last, 9);
        repeat (3) step();
        chk("extra_byte_ovr", ovr_cnt - ovr0, 1);
        check_frame();
        do_done(4'($urandom_range(0, 15)));
        repeat (5) step();
        chk("final_start_count", start_cnt, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute guard so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
